// File: rtl/aging_vector_sequencer.sv
// Vector bank sequencer for aging runs: replays stored vectors into a combinational
// circuit, captures its response after a settle time. Optional MISR: AGING_SEQ_MISR_EN.
module aging_vector_sequencer #(
  parameter int VEC_WIDTH     = 41,
  parameter int OUT_WIDTH     = 32,
  parameter int VEC_DEPTH     = 64,
  parameter int ADDR_W        = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [VEC_WIDTH-1:0] wr_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          loop_count,
  output logic [VEC_WIDTH-1:0] dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 cap_valid,
  output logic [OUT_WIDTH-1:0] cap_data,
  output logic [ADDR_W-1:0]    cap_index,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          signature
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(VEC_DEPTH - 1);
  localparam logic [7:0]        SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [VEC_WIDTH-1:0] mem [VEC_DEPTH];
  logic [ADDR_W-1:0]    idx;
  logic [15:0]          pass;
  logic [15:0]          loop_r;
  logic [15:0]          pass_next;
  logic [7:0]           settle_cnt;

  assign pass_next = pass + 16'd1;

  // Host writes are locked out while a run is driving the circuit.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

`ifdef AGING_SEQ_MISR_EN
  logic [31:0] out32;
  logic [31:0] misr_next;
  assign out32     = 32'(dut_out);
  assign misr_next = ({signature[30:0], 1'b0} ^ (signature[31] ? 32'h0040_0007 : 32'h0)) ^ out32;
`else
  assign signature = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      pass       <= '0;
      loop_r     <= '0;
      settle_cnt <= '0;
      dut_in     <= '0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef AGING_SEQ_MISR_EN
      signature  <= '0;
`endif
    end else begin
      cap_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state  <= S_APPLY;
            idx    <= '0;
            pass   <= '0;
            loop_r <= loop_count;
            busy   <= 1'b1;
            done   <= 1'b0;
`ifdef AGING_SEQ_MISR_EN
            signature <= '0;
`endif
          end
        end
        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            dut_in     <= mem[idx];
            settle_cnt <= SETTLE_INIT;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == 8'd0) begin
            state <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cap_data  <= dut_out;
            cap_index <= idx;
            cap_valid <= 1'b1;
`ifdef AGING_SEQ_MISR_EN
            signature <= misr_next;
`endif
            // A zero loop count never matches, so endless runs just wrap pass.
            if (idx == LAST_IDX) begin
              idx  <= '0;
              pass <= pass_next;
              if (loop_r != 16'd0 && pass_next == loop_r) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_APPLY;
              end
            end else begin
              idx   <= idx + 1'b1;
              state <= S_APPLY;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aging_vector_sequencer.sv
// Self-checking bench for aging_vector_sequencer: scoreboard of expected captures built
// from the vector bank model, with the circuit modelled as dut_out = ~dut_in[31:0].
module tb_aging_vector_sequencer;
  localparam int VW = 41;
  localparam int OW = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } cap_t;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, abort, start2;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic [15:0]   loop_count;
  logic [VW-1:0] dut_in, dut_in2;
  logic [OW-1:0] dut_out, dut_out2, cap_data, cap_data2, inj2;
  logic          cap_valid, cap_valid2, busy, busy2, done, done2;
  logic [AW-1:0] cap_index, cap_index2;
  logic [31:0]   signature, signature2;

  logic [VW-1:0] mem_model [D];
  cap_t          expq [$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  assign dut_out  = ~dut_in[31:0];
  assign dut_out2 = ~dut_in2[31:0] ^ inj2;

  aging_vector_sequencer #(.VEC_WIDTH(VW), .OUT_WIDTH(OW), .VEC_DEPTH(D), .ADDR_W(AW),
                           .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .loop_count(loop_count), .dut_in(dut_in),
    .dut_out(dut_out), .cap_valid(cap_valid), .cap_data(cap_data), .cap_index(cap_index),
    .busy(busy), .done(done), .signature(signature)
  );

  aging_vector_sequencer #(.VEC_WIDTH(VW), .OUT_WIDTH(OW), .VEC_DEPTH(D), .ADDR_W(AW),
                           .SETTLE_CYCLES(4)) u_dut_slow (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start2), .abort(abort), .loop_count(loop_count), .dut_in(dut_in2),
    .dut_out(dut_out2), .cap_valid(cap_valid2), .cap_data(cap_data2), .cap_index(cap_index2),
    .busy(busy2), .done(done2), .signature(signature2)
  );

  // MISR reference: shift-and-reduce by x^32+x^22+x^2+x+1, then fold in the response.
  function automatic logic [31:0] misrStep(input logic [31:0] s, input logic [31:0] d);
    logic [32:0] shifted;
    shifted = {s, 1'b0};
    if (shifted[32]) shifted = shifted ^ 33'h1_0040_0007;
    return shifted[31:0] ^ d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int addr, input logic [VW-1:0] data, input bit accepted);
    wr_addr = AW'(addr);
    wr_data = data;
    wr_en   = 1'b1;
    tick;
    wr_en   = 1'b0;
    if (accepted) mem_model[addr] = data;
  endtask

  task automatic startRun(input logic [15:0] loops, input int passes);
    cap_t e;
    loop_count = loops;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < D; i++) begin
        e.idx  = AW'(i);
        e.data = ~mem_model[i][31:0];
        expq.push_back(e);
      end
  endtask

  task automatic runCollect(input int maxCycles, input int settle, input bit expectDone,
                            input int cyc0);
    int          cyc;
    int          lastCyc;
    logic [31:0] sig;
    cap_t        e;
    cyc = cyc0;
    lastCyc = 0;
    sig = 32'h0;
    while (expq.size() > 0 && cyc < maxCycles) begin
      tick;
      cyc++;
      if (cap_valid) begin
        e = expq.pop_front();
        checkOutput("cap_index", 64'(cap_index), 64'(e.idx));
        checkOutput("cap_data", 64'(cap_data), 64'(e.data));
        checkOutput("cap_spacing", 64'(cyc - lastCyc), 64'(settle + 2));
        checkOutput("done_at_cap", 64'(done), 64'(expectDone && expq.size() == 0));
        lastCyc = cyc;
        sig = misrStep(sig, e.data);
      end else begin
        checkOutput("done_early", 64'(done), 64'(0));
      end
    end
    checkOutput("caps_remaining", 64'(expq.size()), 64'(0));
    expq.delete();
    if (expectDone) begin
      checkOutput("busy_end", 64'(busy), 64'(0));
`ifdef AGING_SEQ_MISR_EN
      checkOutput("signature", 64'(signature), 64'(sig));
`else
      checkOutput("signature", 64'(signature), 64'(0));
`endif
    end
  endtask

  initial begin
    int          passes;
    int          n;
    int          lastC;
    int          idleCaps;
    logic [31:0] mask;
    logic [31:0] expData;
    logic [31:0] sig2;

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_data = '0; loop_count = '0; inj2 = '0;
    tick;
    tick;
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_dut_in", 64'(dut_in), 64'(0));
    checkOutput("rst_cap_valid", 64'(cap_valid), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_signature", 64'(signature), 64'(0));

    $display("[TB] basic run");
    for (int i = 0; i < D; i++) applyStimulus(i, VW'(i + 1), 1'b1);
    startRun(16'd1, 1);
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    runCollect(40, 1, 1'b1, 0);

    $display("[TB] loop and wrap");
    startRun(16'd3, 3);
    runCollect(60, 1, 1'b1, 0);
    repeat (3) tick;
    checkOutput("done_holds", 64'(done), 64'(1));
    checkOutput("dut_in_holds_last", 64'(dut_in), 64'(mem_model[D-1]));

    $display("[TB] random runs");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) applyStimulus(i, {VW'($urandom), $urandom}, 1'b1);
      passes = $urandom_range(1, 3);
      startRun(16'(passes), passes);
      runCollect(passes * D * 3 + 20, 1, 1'b1, 0);
    end

    $display("[TB] settle timing");
    mask = $urandom | 32'h1;
    sig2 = 32'h0;
    n = 0;
    lastC = 0;
    loop_count = 16'd1;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 40 && n < D; cyc++) begin
      tick;
      if (cyc == 9) inj2 = mask;
      if (cap_valid2) begin
        expData = ~mem_model[n][31:0] ^ ((n == 1) ? mask : 32'h0);
        checkOutput("slow_index", 64'(cap_index2), 64'(n));
        checkOutput("slow_data", 64'(cap_data2), 64'(expData));
        checkOutput("slow_spacing", 64'(cyc - lastC), 64'(6));
        sig2 = misrStep(sig2, expData);
        lastC = cyc;
        n++;
      end
      if (cyc == 12) inj2 = '0;
    end
    checkOutput("slow_caps", 64'(n), 64'(D));
    checkOutput("slow_done", 64'(done2), 64'(1));
    checkOutput("slow_busy", 64'(busy2), 64'(0));
`ifdef AGING_SEQ_MISR_EN
    checkOutput("slow_signature", 64'(signature2), 64'(sig2));
`else
    checkOutput("slow_signature", 64'(signature2), 64'(0));
`endif

    $display("[TB] abort during settle of idx 2");
    startRun(16'd1, 1);
    void'(expq.pop_back());
    void'(expq.pop_back());
    runCollect(20, 1, 1'b0, 0);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_done", 64'(done), 64'(0));
    idleCaps = 0;
    for (int c = 0; c < 8; c++) begin
      if (cap_valid) idleCaps++;
      tick;
    end
    checkOutput("abort_no_capture", 64'(idleCaps), 64'(0));
    checkOutput("abort_dut_in_holds", 64'(dut_in), 64'(mem_model[2]));

    $display("[TB] write lockout");
    startRun(16'd1, 1);
    applyStimulus(1, VW'(9), 1'b0);
    runCollect(30, 1, 1'b1, 1);

    $display("[TB] endless mode and reset mid-settle");
    startRun(16'd0, 6);
    runCollect(100, 1, 1'b0, 0);
    checkOutput("endless_busy", 64'(busy), 64'(1));
    checkOutput("endless_done", 64'(done), 64'(0));
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("midrst_dut_in", 64'(dut_in), 64'(0));
    checkOutput("midrst_cap_valid", 64'(cap_valid), 64'(0));
    checkOutput("midrst_cap_data", 64'(cap_data), 64'(0));
    checkOutput("midrst_cap_index", 64'(cap_index), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_done", 64'(done), 64'(0));
    checkOutput("midrst_signature", 64'(signature), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
